// File: rtl/dmem_lsu.sv
// rtl/dmem_lsu.sv - RV32I load/store unit: decodes funct3, strobes data memory, waits out stalls with timeout
// Define LSU_MISALIGN_TRAP_EN to reject misaligned halfword/word accesses with rsp_err.
module dmem_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic        mem_memwrite,
  output logic        mem_memread,
  output logic [3:0]  mem_sign_mask,
  input  logic [31:0] mem_read_data,
  input  logic        mem_clk_stall
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_e;

  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        seen_stall_q, seen_stall_d;
  logic        write_q, write_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        mem_memread_q, mem_memread_d;
  logic        mem_memwrite_q, mem_memwrite_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_write_data_q, mem_write_data_d;
  logic [3:0]  mem_sign_mask_q, mem_sign_mask_d;

  logic [3:0]  dec_mask;
  logic        dec_illegal;
  logic        dec_reject;
  logic [7:0]  cnt_inc;

  always_comb begin
    dec_mask    = 4'b0000;
    dec_illegal = 1'b0;
    case (req_funct3)
      3'b000:  dec_mask = 4'b1001;
      3'b001:  dec_mask = 4'b1011;
      3'b010:  dec_mask = 4'b0111;
      3'b100:  dec_mask = 4'b0001;
      3'b101:  dec_mask = 4'b0011;
      default: dec_illegal = 1'b1;
    endcase
    // Unsigned variants only exist for loads.
    if (req_write && req_funct3[2]) begin
      dec_illegal = 1'b1;
    end
`ifdef LSU_MISALIGN_TRAP_EN
    dec_reject = dec_illegal
               || ((req_funct3[1:0] == 2'b01) && req_addr[0])
               || ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    dec_reject = dec_illegal;
`endif
  end

  assign cnt_inc = cnt_q + 8'd1;

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    seen_stall_d     = seen_stall_q;
    write_d          = write_q;
    rsp_valid_d      = 1'b0;
    rsp_err_d        = 1'b0;
    rsp_rdata_d      = 32'd0;
    mem_memread_d    = 1'b0;
    mem_memwrite_d   = 1'b0;
    mem_addr_d       = mem_addr_q;
    mem_write_data_d = mem_write_data_q;
    mem_sign_mask_d  = mem_sign_mask_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          mem_addr_d       = req_addr;
          mem_write_data_d = req_write ? (req_wdata << {req_addr[1:0], 3'b000}) : 32'd0;
          mem_sign_mask_d  = dec_mask;
          write_d          = req_write;
          if (dec_reject) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            state_d        = S_ISSUE;
            mem_memread_d  = ~req_write;
            mem_memwrite_d = req_write;
          end
        end
      end
      S_ISSUE: begin
        state_d      = S_WAIT;
        seen_stall_d = 1'b0;
        cnt_d        = 8'd0;
      end
      S_WAIT: begin
        // Memory signals done by dropping stall after having raised it.
        if (seen_stall_q && !mem_clk_stall) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = write_q ? 32'd0 : mem_read_data;
        end else begin
          cnt_d        = cnt_inc;
          seen_stall_d = seen_stall_q | mem_clk_stall;
          if (cnt_inc == TIMEOUT_LIM) begin
            state_d     = S_IDLE;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= S_IDLE;
      cnt_q            <= 8'd0;
      seen_stall_q     <= 1'b0;
      write_q          <= 1'b0;
      rsp_valid_q      <= 1'b0;
      rsp_err_q        <= 1'b0;
      rsp_rdata_q      <= 32'd0;
      mem_memread_q    <= 1'b0;
      mem_memwrite_q   <= 1'b0;
      mem_addr_q       <= 32'd0;
      mem_write_data_q <= 32'd0;
      mem_sign_mask_q  <= 4'd0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      seen_stall_q     <= seen_stall_d;
      write_q          <= write_d;
      rsp_valid_q      <= rsp_valid_d;
      rsp_err_q        <= rsp_err_d;
      rsp_rdata_q      <= rsp_rdata_d;
      mem_memread_q    <= mem_memread_d;
      mem_memwrite_q   <= mem_memwrite_d;
      mem_addr_q       <= mem_addr_d;
      mem_write_data_q <= mem_write_data_d;
      mem_sign_mask_q  <= mem_sign_mask_d;
    end
  end

  assign req_ready      = (state_q == S_IDLE);
  assign busy           = (state_q != S_IDLE);
  assign rsp_valid      = rsp_valid_q;
  assign rsp_err        = rsp_err_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign mem_memread    = mem_memread_q;
  assign mem_memwrite   = mem_memwrite_q;
  assign mem_addr       = mem_addr_q;
  assign mem_write_data = mem_write_data_q;
  assign mem_sign_mask  = mem_sign_mask_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// tb/tb_dmem_lsu.sv - self-checking bench for dmem_lsu against a transaction-level reference model
// Honours LSU_MISALIGN_TRAP_EN the same way the design does.
module tb_dmem_lsu;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err, busy;
  logic [31:0] rsp_rdata;
  logic [31:0] mem_addr, mem_write_data, mem_read_data;
  logic        mem_memwrite, mem_memread, mem_clk_stall;
  logic [3:0]  mem_sign_mask;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dmem_lsu #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_memwrite(mem_memwrite), .mem_memread(mem_memread),
    .mem_sign_mask(mem_sign_mask), .mem_read_data(mem_read_data),
    .mem_clk_stall(mem_clk_stall)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] ref_mask(input logic [2:0] f3);
    case (f3)
      3'd0: return 4'b1001;
      3'd1: return 4'b1011;
      3'd2: return 4'b0111;
      3'd4: return 4'b0001;
      default: return 4'b0011;
    endcase
  endfunction

  function automatic bit ref_trap(input logic [2:0] f3, input logic [31:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
    if ((f3 == 3'd1 || f3 == 3'd5) && a[0]) return 1'b1;
    if (f3 == 3'd2 && a[1:0] != 2'b00) return 1'b1;
`endif
    return 1'b0;
  endfunction

  // One full transaction. The stall pattern is high for WAIT cycles [sd, sd+sl);
  // the memory answers on the first low cycle after the burst unless TO cycles elapse first.
  task automatic run_txn(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input int sd, input int sl, input logic [31:0] rd);
    bit f3ok, legal, tmo;
    int wc, done;
    logic [31:0] ewd;
    f3ok  = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5) && !(wr && f3[2]);
    legal = f3ok && !ref_trap(f3, a);
    wc    = (sl > 0) ? sd + sl : 1000000;
    tmo   = legal && (wc >= TO);
    done  = !legal ? 0 : (tmo ? TO + 1 : wc + 2);
    ewd   = wr ? (wd << (8 * a[1:0])) : 32'd0;

    chk("ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = a; req_wdata = wd;
    mem_clk_stall = 1'b0;
    @(posedge clk);
    for (int m = 0; m <= done; m++) begin
      @(negedge clk);
      chk("busy", {31'd0, busy}, {31'd0, legal && m < done});
      chk("req_ready", {31'd0, req_ready}, {31'd0, !(legal && m < done)});
      chk("memread", {31'd0, mem_memread}, {31'd0, legal && !wr && m == 0});
      chk("memwrite", {31'd0, mem_memwrite}, {31'd0, legal && wr && m == 0});
      chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, m == done});
      chk("mem_addr", mem_addr, a);
      if (f3ok) begin
        chk("sign_mask", {28'd0, mem_sign_mask}, {28'd0, ref_mask(f3)});
        chk("write_data", mem_write_data, ewd);
      end
      if (m == done) begin
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, !legal || tmo});
        chk("rsp_rdata", rsp_rdata, (legal && !tmo && !wr) ? rd : 32'd0);
        req_valid = 1'b0;
      end else begin
        req_valid = 1'($urandom_range(0, 1));
        req_write = 1'($urandom_range(0, 1));
        req_funct3 = 3'($urandom_range(0, 7));
        req_addr = $urandom;
        req_wdata = $urandom;
        mem_clk_stall = (m == 0) ? 1'($urandom_range(0, 1)) : ((m - 1 >= sd) && (m - 1 < sd + sl));
        mem_read_data = (m == done - 1) ? rd : $urandom;
        @(posedge clk);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0; mem_read_data = 32'd0; mem_clk_stall = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_sign_mask", {28'd0, mem_sign_mask}, 32'd0);
    chk("rst_strobes", {30'd0, mem_memread, mem_memwrite}, 32'd0);
    rst_n = 1'b1;

    // LW with a single stall cycle: response three edges after accept.
    run_txn(1'b0, 3'd2, 32'h0000_1004, 32'h0, 0, 1, 32'hDEAD_BEEF);
    chk("lw_mask", {28'd0, mem_sign_mask}, 32'h7);
    // SB into byte lane 2.
    run_txn(1'b1, 3'd0, 32'h0000_1002, 32'h0000_00A5, 0, 1, 32'h1234_5678);
    chk("sb_wdata", mem_write_data, 32'h00A5_0000);
    // Illegal funct3 load.
    run_txn(1'b0, 3'd3, 32'h0000_2000, 32'h0, 0, 1, 32'h0);
    // Stall stuck high, then a normal LW back to back.
    run_txn(1'b0, 3'd2, 32'h0000_3000, 32'h0, 0, 1000, 32'h0);
    run_txn(1'b0, 3'd2, 32'h0000_3004, 32'h0, 1, 2, 32'hCAFE_F00D);
    // Misaligned LH, trapped or issued depending on build.
    run_txn(1'b0, 3'd1, 32'h0000_1001, 32'h0, 0, 1, 32'h0000_BEEF);
    // Completion on the last WAIT cycle before timeout, and one cycle too late.
    run_txn(1'b0, 3'd0, 32'h0000_4000, 32'h0, 0, TO - 1, 32'h0000_0055);
    run_txn(1'b0, 3'd0, 32'h0000_4001, 32'h0, 0, TO, 32'h0000_0066);

    for (int i = 0; i < 40; i++) begin
      run_txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
              $urandom_range(0, 4), ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 3), $urandom);
    end

    // Reset during WAIT abandons the access.
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'd2; req_addr = 32'h0000_5000;
    mem_clk_stall = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("wait_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mrst_rsp", {29'd0, rsp_valid, rsp_err, busy}, 32'd0);
    chk("mrst_rdata", rsp_rdata, 32'd0);
    chk("mrst_addr", mem_addr, 32'd0);
    chk("mrst_wdata", mem_write_data, 32'd0);
    chk("mrst_mask_strobes", {26'd0, mem_sign_mask, mem_memread, mem_memwrite}, 32'd0);
    rst_n = 1'b1;
    run_txn(1'b1, 3'd1, 32'h0000_6002, 32'h0000_BEEF, 2, 1, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
